enemy_spawn_scheduler: RTL and testbench
========================================

Name: enemy_spawn_scheduler

Overview:
- Sequences the ten enemy-plane slots of the Y-coordinate datapath.
- Decides when each slot is spawned (its enable is driven high) and when it is retired (a one-cycle destroy pulse), using a periodic spawn timer.
- Tracks score and misses, selects the flying rate from score, and runs the game-level FSM (idle / run / pause / game over).
- Sits between the game top-level (start, pause, collision hits) and the Y-coordinate counter bank.

Parameters:
- NUM_SLOTS, 10, number of enemy slots; fixed at 10 to match the datapath.
- SPAWN_INTERVAL, 25000000, clk cycles between spawn attempts; must be >= 2.
- MAX_ACTIVE, 6, maximum number of simultaneously enabled slots.
- MAX_MISSES, 5, misses that end the game.
- LVL1_SCORE, 10, score at which flying_rate moves to 2'b10.
- LVL2_SCORE, 30, score at which flying_rate moves to 2'b11.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins or restarts a game
- pause  in  1  level; high holds the game in PAUSED
- hit  in  10  per-slot collision pulse from the collision logic
- touch_edge  in  10  per-slot bottom-edge flag from the datapath (y == 120)
- c_en  out  10  per-slot enable to the datapath; registered
- des  out  10  per-slot destroy pulse to the datapath; registered, one cycle wide
- move_en  out  1  move-counter enable; registered
- flying_rate  out  2  speed select to the datapath
- score  out  8  enemies destroyed; saturates at 255
- misses  out  4  enemies that reached the edge; saturates at MAX_MISSES
- active_count  out  4  popcount of c_en; combinational from registered c_en
- game_over  out  1  high while in GAME_OVER

Behaviour:
- Reset: asynchronous, active-high. State = IDLE. c_en = 0, des = 0, move_en = 0, flying_rate = 2'b01, score = 0, misses = 0, game_over = 0. Spawn timer = SPAWN_INTERVAL-1. Round-robin pointer = 0. Reset asserted mid-game aborts immediately.
- FSM:
  - IDLE: start -> RUN.
  - RUN: pause -> PAUSED. misses reaching MAX_MISSES -> GAME_OVER.
  - PAUSED: pause low -> RUN.
  - GAME_OVER: start -> RUN.
  - Every entry into RUN from IDLE or GAME_OVER clears score, misses, c_en and the pointer, and reloads the timer. start is ignored in RUN and PAUSED.
- move_en = 1 only in RUN (registered; asserted the cycle after entering RUN). In PAUSED, the timer, c_en and counters are frozen; hit and touch_edge are ignored.
- Spawn timer (RUN only):
  - Decrements each cycle; at 0 it reloads SPAWN_INTERVAL-1 and performs a spawn attempt.
  - The attempt succeeds if at least one slot has c_en == 0 and active_count < MAX_ACTIVE. Otherwise it is dropped, with no pending retry.
- Slot choice: the first free slot scanning upward from the pointer, wrapping 9 -> 0. The pointer is then set to (chosen+1) mod 10. c_en[chosen] rises the cycle after the timer reaches 0.
- Retire (RUN only), per slot with c_en[i] == 1:
  - If hit[i] or touch_edge[i]: next cycle c_en[i] = 0 and des[i] = 1 for exactly one cycle.
  - hit[i] increments score.
  - touch_edge[i] without hit[i] increments misses.
  - hit and touch_edge in the same cycle count as a hit.
  - hit or touch_edge on a slot with c_en == 0 is ignored.
- Multiple slots retiring in the same cycle: score += popcount(hits), misses += popcount(edge-only), both saturating.
- Spawn and retire in the same cycle: a slot being retired is not eligible for spawn that cycle (eligibility uses the registered c_en). A spawn and a retirement of different slots may coincide.
- Entering GAME_OVER (the cycle misses reaches MAX_MISSES):
  - Next cycle: des = the previous c_en (all live slots pulsed once), c_en = 0, move_en = 0, game_over = 1.
  - score is held.
- flying_rate is registered from score: < LVL1_SCORE -> 2'b01; < LVL2_SCORE -> 2'b10; otherwise 2'b11. 2'b00 is never driven.

Optional Feature:
- Macro: SPAWN_LFSR_EN.
- Defined: a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset; advances every clk in RUN) chooses the scan start as lfsr[3:0] mod 10 instead of the pointer. The pointer is not used.
- Undefined: round-robin as described above. Without the macro, the slot sequence is deterministic.

Test Plan:
- Basic spawn (SPAWN_INTERVAL=8): reset, start -> move_en=1 one cycle later; c_en goes 0x001, then 0x003 eight cycles later, then 0x007.
- Hit: with slot 1 live, pulse hit=0x002 -> next cycle c_en[1]=0, des=0x002 for one cycle, score=1; flying_rate stays 2'b01.
- MAX_ACTIVE cap: MAX_ACTIVE=6, no hits -> c_en saturates at 0x03F; later spawn attempts are dropped. Pulse touch_edge=0x001 -> misses=1; the next spawn fills slot 6 (c_en=0x07E).
- Simultaneous events: with slots 0-2 live, pulse hit=0x005 and touch_edge=0x006 in the same cycle -> score+=2, misses+=1, des=0x007.
- Game over and pause: MAX_MISSES=5; five edge events -> game_over=1, c_en=0, des=previous c_en; pause held 20 cycles mid-run freezes c_en and the timer; start from GAME_OVER -> score=0, misses=0.
- Level and reset: force score to 10 -> flying_rate=2'b10; score 30 -> 2'b11; assert reset mid-run -> all outputs return to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/enemy_spawn_scheduler_if.sv
// Handshake bundle between the game top-level (master) and the enemy
// spawn scheduler (slave): game controls and per-slot events in, slot
// enables, destroy pulses and game status out.
interface enemy_spawn_scheduler_if;
    logic       start;
    logic       pause;
    logic [9:0] hit;
    logic [9:0] touch_edge;
    logic [9:0] c_en;
    logic [9:0] des;
    logic       move_en;
    logic [1:0] flying_rate;
    logic [7:0] score;
    logic [3:0] misses;
    logic [3:0] active_count;
    logic       game_over;

    modport master (
        output start, pause, hit, touch_edge,
        input  c_en, des, move_en, flying_rate, score, misses, active_count, game_over
    );

    modport slave (
        input  start, pause, hit, touch_edge,
        output c_en, des, move_en, flying_rate, score, misses, active_count, game_over
    );
endinterface

// File: rtl/enemy_spawn_scheduler.sv
// Enemy spawn scheduler: game FSM (idle/run/pause/game over), periodic
// spawn timer, slot allocation, retirement on hit/edge, score and miss
// tracking, and flying-rate selection from score.
// Optional build macro SPAWN_LFSR_EN: a 16-bit Galois LFSR picks the slot
// scan start instead of the round-robin pointer.
module enemy_spawn_scheduler #(
    parameter int NUM_SLOTS      = 10,
    parameter int SPAWN_INTERVAL = 25000000,
    parameter int MAX_ACTIVE     = 6,
    parameter int MAX_MISSES     = 5,
    parameter int LVL1_SCORE     = 10,
    parameter int LVL2_SCORE     = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    enemy_spawn_scheduler_if.slave bus
);
    localparam int             TW         = $clog2(SPAWN_INTERVAL);
    localparam logic [TW-1:0]  TIMER_LOAD = TW'(SPAWN_INTERVAL - 1);
    localparam logic [TW-1:0]  TIMER_ZERO = TW'(0);
    localparam logic [3:0]     MISS_CAP   = 4'(MAX_MISSES);
    localparam logic [3:0]     ACTIVE_CAP = 4'(MAX_ACTIVE);
    localparam logic [3:0]     LAST_SLOT  = 4'(NUM_SLOTS - 1);
    localparam logic [4:0]     SLOTS5     = 5'(NUM_SLOTS);
    localparam logic [7:0]     LVL1       = 8'(LVL1_SCORE);
    localparam logic [7:0]     LVL2       = 8'(LVL2_SCORE);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        PAUSED    = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    function automatic logic [3:0] popcount(input logic [NUM_SLOTS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    state_t                state_r, state_s;
    logic [NUM_SLOTS-1:0]  c_en_r, c_en_s, des_r, des_s;
    logic [NUM_SLOTS-1:0]  hits_s, edge_s, spawn_s;
    logic [TW-1:0]         timer_r, timer_s;
    logic [7:0]            score_r, score_s;
    logic [8:0]            score_sum_s;
    logic [3:0]            misses_r, misses_s;
    logic [4:0]            miss_sum_s;
    logic                  move_en_r, game_over_r;
    logic [1:0]            rate_r, rate_s;
    logic [3:0]            active_s, scan_start_s, pick_s;
    logic [4:0]            idx_s;
    logic                  found_s;

    // Only live slots can retire; a simultaneous hit and edge counts as a hit.
    assign hits_s   = bus.hit & c_en_r;
    assign edge_s   = bus.touch_edge & c_en_r & ~bus.hit;
    assign active_s = popcount(c_en_r);

`ifdef SPAWN_LFSR_EN
    logic [15:0] lfsr_r;

    // Advance the scan-start LFSR every cycle spent in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= 16'hACE1;
        end else if (state_r == RUN) begin
            lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign scan_start_s = (lfsr_r[3:0] >= 4'd10) ? (lfsr_r[3:0] - 4'd10) : lfsr_r[3:0];
`else
    logic [3:0] ptr_r, ptr_s;
    assign scan_start_s = ptr_r;
`endif

    // Find the first free slot scanning upward from the scan start, wrapping.
    always_comb begin
        pick_s  = 4'd0;
        found_s = 1'b0;
        idx_s   = 5'd0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            idx_s = {1'b0, scan_start_s} + 5'(k);
            if (idx_s >= SLOTS5) begin
                idx_s = idx_s - SLOTS5;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && !c_en_r[idx_s[3:0]]) begin
                found_s = 1'b1;
                pick_s  = idx_s[3:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and datapath updates for the game FSM.
    always_comb begin
        state_s     = state_r;
        c_en_s      = c_en_r;
        des_s       = {NUM_SLOTS{1'b0}};
        timer_s     = timer_r;
        score_s     = score_r;
        misses_s    = misses_r;
        spawn_s     = {NUM_SLOTS{1'b0}};
        score_sum_s = 9'd0;
        miss_sum_s  = 5'd0;
`ifndef SPAWN_LFSR_EN
        ptr_s       = ptr_r;
`endif
        case (state_r)
            IDLE, GAME_OVER: begin
                if (bus.start) begin
                    state_s  = RUN;
                    c_en_s   = {NUM_SLOTS{1'b0}};
                    timer_s  = TIMER_LOAD;
                    score_s  = 8'd0;
                    misses_s = 4'd0;
`ifndef SPAWN_LFSR_EN
                    ptr_s    = 4'd0;
`endif
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                c_en_s      = c_en_r & ~(hits_s | edge_s);
                des_s       = hits_s | edge_s;
                score_sum_s = {1'b0, score_r} + {5'd0, popcount(hits_s)};
                score_s     = (score_sum_s > 9'd255) ? 8'd255 : score_sum_s[7:0];
                miss_sum_s  = {1'b0, misses_r} + {1'b0, popcount(edge_s)};
                misses_s    = (miss_sum_s >= {1'b0, MISS_CAP}) ? MISS_CAP : miss_sum_s[3:0];
                if (timer_r == TIMER_ZERO) begin
                    timer_s = TIMER_LOAD;
                    // Eligibility uses registered c_en, so retiring slots cannot respawn now.
                    if (found_s && (active_s < ACTIVE_CAP)) begin
                        spawn_s[pick_s] = 1'b1;
                        c_en_s          = c_en_s | spawn_s;
`ifndef SPAWN_LFSR_EN
                        ptr_s           = (pick_s == LAST_SLOT) ? 4'd0 : (pick_s + 4'd1);
`endif
                    end else begin
                        c_en_s = c_en_s;
                    end
                end else begin
                    timer_s = timer_r - TW'(1);
                end
                if (misses_s == MISS_CAP) begin
                    state_s = GAME_OVER;
                    des_s   = c_en_r;
                    c_en_s  = {NUM_SLOTS{1'b0}};
                end else if (bus.pause) begin
                    state_s = PAUSED;
                end else begin
                    state_s = RUN;
                end
            end
            PAUSED: begin
                if (!bus.pause) begin
                    state_s = RUN;
                end else begin
                    state_s = PAUSED;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (score_s < LVL1) begin
            rate_s = 2'b01;
        end else if (score_s < LVL2) begin
            rate_s = 2'b10;
        end else begin
            rate_s = 2'b11;
        end
    end

    // State and registered outputs; reset aborts a game immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            c_en_r      <= {NUM_SLOTS{1'b0}};
            des_r       <= {NUM_SLOTS{1'b0}};
            timer_r     <= TIMER_LOAD;
            score_r     <= 8'd0;
            misses_r    <= 4'd0;
            move_en_r   <= 1'b0;
            game_over_r <= 1'b0;
            rate_r      <= 2'b01;
`ifndef SPAWN_LFSR_EN
            ptr_r       <= 4'd0;
`endif
        end else begin
            state_r     <= state_s;
            c_en_r      <= c_en_s;
            des_r       <= des_s;
            timer_r     <= timer_s;
            score_r     <= score_s;
            misses_r    <= misses_s;
            move_en_r   <= (state_s == RUN);
            game_over_r <= (state_s == GAME_OVER);
            rate_r      <= rate_s;
`ifndef SPAWN_LFSR_EN
            ptr_r       <= ptr_s;
`endif
        end
    end

    assign bus.c_en         = c_en_r;
    assign bus.des          = des_r;
    assign bus.move_en      = move_en_r;
    assign bus.flying_rate  = rate_r;
    assign bus.score        = score_r;
    assign bus.misses       = misses_r;
    assign bus.active_count = active_s;
    assign bus.game_over    = game_over_r;
endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Directed bench for enemy_spawn_scheduler with SPAWN_INTERVAL=8.
// Inputs are driven and outputs sampled on the falling clock edge.
// After a start, spawns land on the 8th, 16th, ... rising edge after the
// edge that entered RUN.
module tb_enemy_spawn_scheduler;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    enemy_spawn_scheduler_if bus();

    enemy_spawn_scheduler #(
        .NUM_SLOTS(10), .SPAWN_INTERVAL(8), .MAX_ACTIVE(6),
        .MAX_MISSES(5), .LVL1_SCORE(10), .LVL2_SCORE(30)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset, then start a game; returns just after the edge that entered RUN.
    task automatic restart();
        bus.start = 1'b0; bus.pause = 1'b0; bus.hit = 10'h000; bus.touch_edge = 10'h000;
        reset = 1'b1; step(2); reset = 1'b0; step(1);
        bus.start = 1'b1; step(1); bus.start = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        total++; if (bus.c_en !== 10'h000) begin bad++; $display("FAIL rst_c_en got=%h exp=000", bus.c_en); end
        total++; if (bus.des !== 10'h000) begin bad++; $display("FAIL rst_des got=%h exp=000", bus.des); end
        total++; if (bus.move_en !== 1'b0) begin bad++; $display("FAIL rst_move_en got=%b exp=0", bus.move_en); end
        total++; if (bus.flying_rate !== 2'b01) begin bad++; $display("FAIL rst_rate got=%b exp=01", bus.flying_rate); end
        total++; if (bus.score !== 8'd0 || bus.misses !== 4'd0) begin bad++; $display("FAIL rst_counts score=%0d misses=%0d exp=0/0", bus.score, bus.misses); end
        total++; if (bus.game_over !== 1'b0 || bus.active_count !== 4'd0) begin bad++; $display("FAIL rst_status go=%b act=%0d exp=0/0", bus.game_over, bus.active_count); end
    endtask

    task automatic test_basic_spawn();
        restart();
        total++; if (bus.move_en !== 1'b1) begin bad++; $display("FAIL basic_move_en got=%b exp=1", bus.move_en); end
        step(7);
        total++; if (bus.c_en !== 10'h000) begin bad++; $display("FAIL basic_early got=%h exp=000", bus.c_en); end
        step(1);
        total++; if (bus.c_en !== 10'h001) begin bad++; $display("FAIL basic_first got=%h exp=001", bus.c_en); end
        step(8);
        total++; if (bus.c_en !== 10'h003) begin bad++; $display("FAIL basic_second got=%h exp=003", bus.c_en); end
        bus.start = 1'b1; step(1); bus.start = 1'b0;
        total++; if (bus.c_en !== 10'h003) begin bad++; $display("FAIL basic_start_in_run got=%h exp=003", bus.c_en); end
        step(7);
        total++; if (bus.c_en !== 10'h007 || bus.active_count !== 4'd3) begin bad++; $display("FAIL basic_third c_en=%h act=%0d exp=007/3", bus.c_en, bus.active_count); end
    endtask

    task automatic test_hit();
        restart(); step(16);
        bus.hit = 10'h002; step(1); bus.hit = 10'h000;
        total++; if (bus.c_en !== 10'h001) begin bad++; $display("FAIL hit_c_en got=%h exp=001", bus.c_en); end
        total++; if (bus.des !== 10'h002) begin bad++; $display("FAIL hit_des got=%h exp=002", bus.des); end
        total++; if (bus.score !== 8'd1 || bus.flying_rate !== 2'b01) begin bad++; $display("FAIL hit_score score=%0d rate=%b exp=1/01", bus.score, bus.flying_rate); end
        step(1);
        total++; if (bus.des !== 10'h000) begin bad++; $display("FAIL hit_des_width got=%h exp=000", bus.des); end
    endtask

    task automatic test_max_active();
        restart(); step(48);
        total++; if (bus.c_en !== 10'h03F || bus.active_count !== 4'd6) begin bad++; $display("FAIL cap_fill c_en=%h act=%0d exp=03F/6", bus.c_en, bus.active_count); end
        step(16);
        total++; if (bus.c_en !== 10'h03F) begin bad++; $display("FAIL cap_dropped got=%h exp=03F", bus.c_en); end
        bus.touch_edge = 10'h001; step(1); bus.touch_edge = 10'h000;
        total++; if (bus.misses !== 4'd1 || bus.des !== 10'h001) begin bad++; $display("FAIL cap_miss misses=%0d des=%h exp=1/001", bus.misses, bus.des); end
        step(7);
        total++; if (bus.c_en !== 10'h07E) begin bad++; $display("FAIL cap_refill got=%h exp=07E", bus.c_en); end
    endtask

    task automatic test_simultaneous();
        restart(); step(24);
        bus.hit = 10'h205; bus.touch_edge = 10'h006; step(1);
        bus.hit = 10'h000; bus.touch_edge = 10'h000;
        total++; if (bus.des !== 10'h007 || bus.c_en !== 10'h000) begin bad++; $display("FAIL simul_des des=%h c_en=%h exp=007/000", bus.des, bus.c_en); end
        total++; if (bus.score !== 8'd2 || bus.misses !== 4'd1) begin bad++; $display("FAIL simul_counts score=%0d misses=%0d exp=2/1", bus.score, bus.misses); end
    endtask

    task automatic test_pause();
        restart(); step(10);
        bus.pause = 1'b1; step(1);
        total++; if (bus.move_en !== 1'b0 || bus.c_en !== 10'h001) begin bad++; $display("FAIL pause_enter move_en=%b c_en=%h exp=0/001", bus.move_en, bus.c_en); end
        step(9);
        bus.hit = 10'h001; step(1); bus.hit = 10'h000;
        total++; if (bus.c_en !== 10'h001 || bus.score !== 8'd0 || bus.des !== 10'h000) begin bad++; $display("FAIL pause_hit_ignored c_en=%h score=%0d des=%h exp=001/0/000", bus.c_en, bus.score, bus.des); end
        step(9);
        bus.pause = 1'b0; step(1);
        total++; if (bus.move_en !== 1'b1) begin bad++; $display("FAIL pause_resume got=%b exp=1", bus.move_en); end
        step(4);
        total++; if (bus.c_en !== 10'h001) begin bad++; $display("FAIL pause_timer_early got=%h exp=001", bus.c_en); end
        step(1);
        total++; if (bus.c_en !== 10'h003) begin bad++; $display("FAIL pause_timer_spawn got=%h exp=003", bus.c_en); end
    endtask

    task automatic test_game_over();
        restart(); step(40);
        bus.touch_edge = 10'h001; step(1);
        bus.touch_edge = 10'h002; step(1);
        bus.touch_edge = 10'h000; bus.hit = 10'h004; step(1);
        bus.hit = 10'h000; bus.touch_edge = 10'h008; step(1);
        bus.touch_edge = 10'h000;
        total++; if (bus.misses !== 4'd3 || bus.score !== 8'd1 || bus.c_en !== 10'h010) begin bad++; $display("FAIL go_pre misses=%0d score=%0d c_en=%h exp=3/1/010", bus.misses, bus.score, bus.c_en); end
        step(12);
        total++; if (bus.c_en !== 10'h070) begin bad++; $display("FAIL go_live got=%h exp=070", bus.c_en); end
        bus.touch_edge = 10'h050; step(1); bus.touch_edge = 10'h000;
        total++; if (bus.game_over !== 1'b1 || bus.move_en !== 1'b0) begin bad++; $display("FAIL go_enter go=%b move_en=%b exp=1/0", bus.game_over, bus.move_en); end
        total++; if (bus.des !== 10'h070 || bus.c_en !== 10'h000) begin bad++; $display("FAIL go_des des=%h c_en=%h exp=070/000", bus.des, bus.c_en); end
        total++; if (bus.misses !== 4'd5 || bus.score !== 8'd1) begin bad++; $display("FAIL go_counts misses=%0d score=%0d exp=5/1", bus.misses, bus.score); end
        step(10);
        total++; if (bus.des !== 10'h000 || bus.c_en !== 10'h000 || bus.game_over !== 1'b1) begin bad++; $display("FAIL go_hold des=%h c_en=%h go=%b exp=000/000/1", bus.des, bus.c_en, bus.game_over); end
        bus.start = 1'b1; step(1); bus.start = 1'b0;
        total++; if (bus.score !== 8'd0 || bus.misses !== 4'd0 || bus.game_over !== 1'b0 || bus.move_en !== 1'b1) begin bad++; $display("FAIL go_restart score=%0d misses=%0d go=%b move_en=%b exp=0/0/0/1", bus.score, bus.misses, bus.game_over, bus.move_en); end
        step(8);
        total++; if (bus.c_en !== 10'h001) begin bad++; $display("FAIL go_restart_spawn got=%h exp=001", bus.c_en); end
    endtask

    task automatic test_level_and_reset();
        logic [9:0] hv;
        logic [1:0] exp_rate;
        restart(); step(8);
        for (int i = 0; i < 30; i++) begin
            hv = 10'd1 << (i % 10);
            bus.hit = hv; step(1); bus.hit = 10'h000;
            total++; if (bus.score !== 8'(i + 1)) begin bad++; $display("FAIL level_score%0d got=%0d exp=%0d", i, bus.score, i + 1); end
            if (i == 8 || i == 9 || i == 28 || i == 29) begin
                exp_rate = (i + 1 < 10) ? 2'b01 : ((i + 1 < 30) ? 2'b10 : 2'b11);
                total++; if (bus.flying_rate !== exp_rate) begin bad++; $display("FAIL level_rate%0d got=%b exp=%b", i, bus.flying_rate, exp_rate); end
            end
            step(7);
        end
        #2 reset = 1'b1;
        #1;
        total++; if (bus.c_en !== 10'h000 || bus.move_en !== 1'b0 || bus.game_over !== 1'b0) begin bad++; $display("FAIL async_rst_outs c_en=%h move_en=%b go=%b exp=000/0/0", bus.c_en, bus.move_en, bus.game_over); end
        total++; if (bus.score !== 8'd0 || bus.flying_rate !== 2'b01 || bus.active_count !== 4'd0) begin bad++; $display("FAIL async_rst_counts score=%0d rate=%b act=%0d exp=0/01/0", bus.score, bus.flying_rate, bus.active_count); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.pause = 1'b0; bus.hit = 10'h000; bus.touch_edge = 10'h000;
        test_reset();
        test_basic_spawn();
        test_hit();
        test_max_active();
        test_simultaneous();
        test_pause();
        test_game_over();
        test_level_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
